// File: rtl/mem_arbiter.sv
// Shares one wishbone memory port between video DMA, sound DMA and the CPU.
// Fixed priority video > sound > CPU. A starved CPU may pass sound, never video.
module mem_arbiter #(
    parameter int BURST_LEN    = 4,
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic        clkcpu,
    input  logic        rst_i,
    input  logic        vid_req,
    input  logic [21:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_done,
    input  logic        snd_req,
    input  logic [21:0] snd_addr,
    output logic        snd_ack,
    output logic        snd_done,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [21:0] cpu_addr,
    output logic        cpu_ack,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [2:0]  mem_cti_o,
    output logic [21:0] mem_addr_o,
    input  logic        mem_ack_i,
    output logic [1:0]  grant_o
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CPU  = 2'b01;
    localparam logic [1:0] S_VID  = 2'b10;
    localparam logic [1:0] S_SND  = 2'b11;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(CPU_MAX_WAIT);
    localparam logic [21:0]       BLOCK_MASK = ~22'(BURST_LEN - 1);

    logic [1:0]        state;
    logic [1:0]        pick;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] next_beat;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cpu_live;
    logic              cpu_pend;
    logic              last_beat;

    assign cpu_pend  = cpu_cyc & cpu_stb;
    assign next_beat = beat + BEAT_W'(1);
    assign last_beat = (beat == LAST_BEAT);
    assign grant_o   = state;

    assign vid_ack  = (state == S_VID) & mem_ack_i;
    assign snd_ack  = (state == S_SND) & mem_ack_i;
    assign vid_done = vid_ack & last_beat;
    assign snd_done = snd_ack & last_beat;
    // A CPU that withdrew its strobe mid-cycle gets no acknowledge for it.
    assign cpu_ack  = (state == S_CPU) & mem_ack_i & cpu_live & cpu_pend;

    always_comb begin
        pick = S_IDLE;
        if (vid_req)
            pick = S_VID;
        else if (cpu_pend && wait_cnt == WAIT_MAX)
            pick = S_CPU;
        else if (snd_req)
            pick = S_SND;
        else if (cpu_pend)
            pick = S_CPU;
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state      <= S_IDLE;
            beat       <= '0;
            wait_cnt   <= '0;
            cpu_live   <= 1'b0;
            mem_cyc_o  <= 1'b0;
            mem_stb_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= 4'b0000;
            mem_cti_o  <= CTI_CLASSIC;
            mem_addr_o <= '0;
        end else begin
            if (state == S_IDLE && pick == S_CPU)
                wait_cnt <= '0;
            else if (cpu_pend && state != S_CPU && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            case (state)
                S_IDLE: begin
                    if (pick != S_IDLE) begin
                        state     <= pick;
                        mem_cyc_o <= 1'b1;
                        mem_stb_o <= 1'b1;
                        beat      <= '0;
                    end
                    case (pick)
                        S_CPU: begin
                            mem_we_o   <= cpu_we;
                            mem_sel_o  <= cpu_sel;
                            mem_cti_o  <= CTI_CLASSIC;
                            mem_addr_o <= cpu_addr;
                            cpu_live   <= 1'b1;
                        end
                        S_VID: begin
                            mem_we_o   <= 1'b0;
                            mem_sel_o  <= 4'b1111;
                            mem_cti_o  <= CTI_INCR;
                            mem_addr_o <= vid_addr & BLOCK_MASK;
                        end
                        S_SND: begin
                            mem_we_o   <= 1'b0;
                            mem_sel_o  <= 4'b1111;
                            mem_cti_o  <= CTI_INCR;
                            mem_addr_o <= snd_addr & BLOCK_MASK;
                        end
                        default: ;
                    endcase
                end
                S_CPU: begin
                    if (!cpu_pend)
                        cpu_live <= 1'b0;
                    if (mem_ack_i) begin
                        state     <= S_IDLE;
                        mem_cyc_o <= 1'b0;
                        mem_stb_o <= 1'b0;
                        cpu_live  <= 1'b0;
                    end
                end
                default: begin
                    // Burst beats wrap inside the aligned block; only the low bits advance.
                    if (mem_ack_i) begin
                        if (last_beat) begin
                            state     <= S_IDLE;
                            mem_cyc_o <= 1'b0;
                            mem_stb_o <= 1'b0;
                            beat      <= '0;
                        end else begin
                            beat       <= next_beat;
                            mem_addr_o <= {mem_addr_o[21:BEAT_W], next_beat};
                            mem_cti_o  <= (next_beat == LAST_BEAT) ? CTI_END : CTI_INCR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory beats are queued when a
// scenario is set up and popped by a monitor whenever the memory acknowledges.
module tb_mem_arbiter;

    localparam int BURST_LEN    = 4;
    localparam int CPU_MAX_WAIT = 16;

    logic        clkcpu;
    logic        rst_i;
    logic        vid_req, snd_req;
    logic [21:0] vid_addr, snd_addr, cpu_addr;
    logic        vid_ack, vid_done, snd_ack, snd_done;
    logic        cpu_cyc, cpu_stb, cpu_we, cpu_ack;
    logic [3:0]  cpu_sel;
    logic        mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i;
    logic [3:0]  mem_sel_o;
    logic [2:0]  mem_cti_o;
    logic [21:0] mem_addr_o;
    logic [1:0]  grant_o;

    typedef struct packed {
        logic [21:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  grant;
        logic        done;
        logic        cack;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    vid_done_cnt = 0;
    int    cpu_ack_cnt = 0;
    int    ack_delay = 0;
    bit    force_ack = 1'b0;

    mem_arbiter #(.BURST_LEN(BURST_LEN), .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
        .clkcpu(clkcpu), .rst_i(rst_i),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_done(vid_done),
        .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_done(snd_done),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_sel_o(mem_sel_o), .mem_cti_o(mem_cti_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .grant_o(grant_o)
    );

    initial clkcpu = 1'b0;
    always #5 clkcpu = ~clkcpu;

    // Memory responder: acks ack_delay cycles into each beat, or every cycle when 0.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i = 1'b0;
        forever begin
            @(posedge clkcpu);
            #1;
            if (force_ack) begin
                mem_ack_i = 1'b1;
            end else if (rst_i || !(mem_cyc_o && mem_stb_o)) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (mem_ack_i && ack_delay > 0) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                mem_ack_i = (cnt >= ack_delay);
            end
        end
    end

    // Monitor: every acknowledged beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clkcpu);
            if (!rst_i) begin
                if (vid_done) vid_done_cnt++;
                if (cpu_ack) cpu_ack_cnt++;
            end
            if (!rst_i && mem_cyc_o && mem_stb_o && mem_ack_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got addr=%h grant=%b, expected no beat",
                             mem_addr_o, grant_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr_o, mem_cti_o, mem_we_o, mem_sel_o, grant_o} !==
                        {e.addr, e.cti, e.we, e.sel, e.grant}) begin
                        n_fail++;
                        $display("[TB] FAIL beat_fields: got addr=%h cti=%b we=%b sel=%b grant=%b, expected addr=%h cti=%b we=%b sel=%b grant=%b",
                                 mem_addr_o, mem_cti_o, mem_we_o, mem_sel_o, grant_o,
                                 e.addr, e.cti, e.we, e.sel, e.grant);
                    end
                    n_checks++;
                    if ({vid_ack, snd_ack, cpu_ack, vid_done, snd_done} !==
                        {e.grant == 2'b10, e.grant == 2'b11, e.grant == 2'b01 && e.cack,
                         e.done && e.grant == 2'b10, e.done && e.grant == 2'b11}) begin
                        n_fail++;
                        $display("[TB] FAIL beat_acks: got vid/snd/cpu ack, vid/snd done=%b%b%b%b%b for grant=%b done=%b cack=%b",
                                 vid_ack, snd_ack, cpu_ack, vid_done, snd_done, e.grant, e.done, e.cack);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_burst(input logic [1:0] g, input logic [21:0] a);
        beat_t e;
        logic [21:0] base;
        base = a & ~22'(BURST_LEN - 1);
        for (int i = 0; i < BURST_LEN; i++) begin
            e.addr  = base | 22'(i);
            e.cti   = (i == BURST_LEN - 1) ? 3'b111 : 3'b010;
            e.we    = 1'b0;
            e.sel   = 4'b1111;
            e.grant = g;
            e.done  = (i == BURST_LEN - 1);
            e.cack  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_cpu(input logic [21:0] a, input logic we, input logic [3:0] sel,
                            input logic cack);
        beat_t e;
        e.addr = a; e.cti = 3'b000; e.we = we; e.sel = sel;
        e.grant = 2'b01; e.done = 1'b0; e.cack = cack;
        exp_q.push_back(e);
    endtask

    task automatic wait_queue(input int target, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clkcpu);
            #1;
            n++;
        end while (exp_q.size() > target && n < budget);
        if (exp_q.size() > target) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: %0d beats outstanding, expected %0d", name,
                     exp_q.size(), target);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        vid_req = 1'b0; snd_req = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        cpu_sel = 4'b0000; vid_addr = '0; snd_addr = '0; cpu_addr = '0;
        force_ack = 1'b0; ack_delay = 0;
        repeat (2) begin
            @(posedge clkcpu);
            #1;
        end
        exp_q.delete();
        vid_done_cnt = 0;
        cpu_ack_cnt = 0;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        vid_req = 1'b1; snd_req = 1'b1; cpu_cyc = 1'b1; cpu_stb = 1'b1;
        cpu_we = 1'b1; cpu_sel = 4'b1010; cpu_addr = 22'h000777;
        vid_addr = 22'h00ABC7; snd_addr = 22'h002340; ack_delay = 0;
        repeat (3) begin
            @(posedge clkcpu);
            #1;
        end
        n_checks++;
        if ({mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o} !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got cyc/stb/we/sel/cti=%b, expected all zero",
                     {mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o});
        end
        n_checks++;
        if (mem_addr_o !== 22'h0 || grant_o !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_addr_grant: got addr=%h grant=%b, expected 000000/00",
                     mem_addr_o, grant_o);
        end
        n_checks++;
        if ({vid_ack, snd_ack, cpu_ack, vid_done, snd_done} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_acks: got %b, expected 00000",
                     {vid_ack, snd_ack, cpu_ack, vid_done, snd_done});
        end
        push_burst(2'b10, vid_addr);
        rst_i = 1'b0;
        @(posedge clkcpu);
        #1;
        n_checks++;
        if (grant_o !== 2'b10 || mem_addr_o !== 22'h00ABC4 || mem_cti_o !== 3'b010 ||
            mem_cyc_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got grant=%b addr=%h cti=%b cyc=%b, expected 10/00abc4/010/1",
                     grant_o, mem_addr_o, mem_cti_o, mem_cyc_o);
        end
        wait_queue(0, 30, "reset_release");
        vid_req = 1'b0; snd_req = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
    endtask

    task automatic test_video_burst();
        do_reset();
        vid_addr = 22'h001234;
        push_burst(2'b10, vid_addr);
        vid_req = 1'b1;
        wait_queue(0, 30, "video_burst");
        vid_req = 1'b0;
        n_checks++;
        if (mem_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL video_end_idle: got cyc=%b grant=%b, expected 0/00", mem_cyc_o, grant_o);
        end
        n_checks++;
        if (vid_done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL video_done_count: got %0d, expected 1", vid_done_cnt);
        end
    endtask

    task automatic test_cpu_write();
        do_reset();
        ack_delay = 3;
        cpu_addr = 22'h000100; cpu_sel = 4'b0101; cpu_we = 1'b1;
        push_cpu(cpu_addr, 1'b1, 4'b0101, 1'b1);
        cpu_cyc = 1'b1; cpu_stb = 1'b1;
        @(posedge clkcpu);
        #1;
        n_checks++;
        if (grant_o !== 2'b01 || mem_we_o !== 1'b1 || mem_sel_o !== 4'b0101 ||
            mem_cti_o !== 3'b000 || mem_cyc_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cpu_grant: got grant=%b we=%b sel=%b cti=%b cyc=%b, expected 01/1/0101/000/1",
                     grant_o, mem_we_o, mem_sel_o, mem_cti_o, mem_cyc_o);
        end
        wait_queue(0, 20, "cpu_write");
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        n_checks++;
        if (mem_cyc_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cpu_cyc_fall: got cyc=%b on ack edge, expected 0", mem_cyc_o);
        end
        repeat (3) begin
            @(posedge clkcpu);
            #1;
        end
        n_checks++;
        if (cpu_ack_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL cpu_ack_count: got %0d, expected 1", cpu_ack_cnt);
        end
        // An ack arriving while idle must not reach any requester.
        force_ack = 1'b1;
        @(posedge clkcpu);
        #2;
        @(negedge clkcpu);
        n_checks++;
        if ({vid_ack, snd_ack, cpu_ack, vid_done, snd_done} !== 5'b0 || grant_o !== 2'b00 ||
            mem_ack_i !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_ack: got acks=%b grant=%b mem_ack=%b, expected 00000/00/1",
                     {vid_ack, snd_ack, cpu_ack, vid_done, snd_done}, grant_o, mem_ack_i);
        end
        force_ack = 1'b0;
        repeat (2) begin
            @(posedge clkcpu);
            #1;
        end
    endtask

    task automatic test_cpu_abort();
        do_reset();
        ack_delay = 3;
        cpu_addr = 22'h000300; cpu_sel = 4'b1111; cpu_we = 1'b0;
        push_cpu(cpu_addr, 1'b0, 4'b1111, 1'b0);
        cpu_cyc = 1'b1; cpu_stb = 1'b1;
        @(posedge clkcpu);
        #1;
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        wait_queue(0, 20, "cpu_abort");
        n_checks++;
        if (cpu_ack_cnt !== 0 || mem_cyc_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cpu_abort: got cpu_ack count=%0d cyc=%b, expected 0/0",
                     cpu_ack_cnt, mem_cyc_o);
        end
    endtask

    task automatic test_starvation();
        int w;
        int bursts;
        do_reset();
        snd_addr = 22'h002340;
        cpu_addr = 22'h000200; cpu_sel = 4'b1111; cpu_we = 1'b0;
        // Wait count seen at each IDLE visit grows by one burst plus the idle cycle.
        w = 0;
        bursts = 0;
        while (w < CPU_MAX_WAIT) begin
            push_burst(2'b11, snd_addr);
            bursts++;
            w = w + BURST_LEN + 1;
            if (w > CPU_MAX_WAIT) w = CPU_MAX_WAIT;
        end
        push_cpu(cpu_addr, 1'b0, 4'b1111, 1'b1);
        snd_req = 1'b1; cpu_cyc = 1'b1; cpu_stb = 1'b1;
        wait_queue(0, 200, "starvation");
        snd_req = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
        n_checks++;
        if (cpu_ack_cnt !== 1 || bursts !== 4) begin
            n_fail++;
            $display("[TB] FAIL starvation_cpu: got cpu_ack count=%0d after %0d sound bursts, expected 1 after 4",
                     cpu_ack_cnt, bursts);
        end
    endtask

    task automatic test_video_preempt();
        do_reset();
        ack_delay = 5;
        snd_addr = 22'h002342;
        vid_addr = 22'h003F0B;
        cpu_addr = 22'h000400; cpu_sel = 4'b1111; cpu_we = 1'b0;
        push_burst(2'b11, snd_addr);
        push_burst(2'b10, vid_addr);
        push_cpu(cpu_addr, 1'b0, 4'b1111, 1'b1);
        snd_req = 1'b1; cpu_cyc = 1'b1; cpu_stb = 1'b1;
        wait_queue(2 * BURST_LEN, 40, "preempt_beat0");
        vid_req = 1'b1;
        wait_queue(BURST_LEN + 1, 100, "preempt_sound");
        snd_req = 1'b0;
        n_checks++;
        if (mem_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL preempt_idle_gap: got cyc=%b grant=%b, expected 0/00", mem_cyc_o, grant_o);
        end
        @(posedge clkcpu);
        #1;
        n_checks++;
        if (grant_o !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL preempt_video_wins: got grant=%b, expected 10", grant_o);
        end
        wait_queue(1, 100, "preempt_video");
        vid_req = 1'b0;
        wait_queue(0, 40, "preempt_cpu");
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        vid_addr = 22'h000560;
        push_burst(2'b10, vid_addr);
        vid_req = 1'b1;
        wait_queue(BURST_LEN - 2, 30, "midreset_beat2");
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clkcpu);
        #1;
        n_checks++;
        if (mem_cyc_o !== 1'b0 || grant_o !== 2'b00 || mem_addr_o !== 22'h0 ||
            mem_cti_o !== 3'b000 || vid_done !== 1'b0 || vid_done_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_abort: got cyc=%b grant=%b addr=%h cti=%b done=%b count=%0d, expected 0/00/000000/000/0/0",
                     mem_cyc_o, grant_o, mem_addr_o, mem_cti_o, vid_done, vid_done_cnt);
        end
        push_burst(2'b10, vid_addr);
        rst_i = 1'b0;
        wait_queue(0, 30, "midreset_restart");
        vid_req = 1'b0;
        n_checks++;
        if (vid_done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL midreset_done_count: got %0d, expected 1", vid_done_cnt);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        vid_req = 1'b0; snd_req = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        cpu_sel = 4'b0000; vid_addr = '0; snd_addr = '0; cpu_addr = '0;
        @(posedge clkcpu);
        #1;
        test_reset();
        test_video_burst();
        test_cpu_write();
        test_cpu_abort();
        test_starvation();
        test_video_preempt();
        test_reset_mid_burst();
        repeat (3) begin
            @(posedge clkcpu);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL leftover_beats: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
